// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and the default datapath width.
package rv32m_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and emit one quotient bit.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // rem < divisor keeps shifted below 2*divisor, so the top bit of diff is a clean borrow
        if (diff[XLEN]) begin
            next_rem = shifted[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b0};
        end else begin
            next_rem = diff[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add multiply or
// restoring divide over 32 cycles, then a single sign-fix cycle.
module mul_div_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output state_t          dbg_state
);

    localparam int CW = $clog2(XLEN);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic [XLEN-1:0] hi, lo, opb;
    logic            neg_q, neg_r;

    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div   = funct3[2];
        a_sgn    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_sgn    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_sgn & a[XLEN-1];
        b_neg    = b_sgn & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && b_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        if (div_zero)
            special_res = funct3[1] ? a : '1;
        else
            special_res = funct3[1] ? '0 : a;
    end

    logic [XLEN-1:0] div_rem, div_quo;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (hi),
        .quo      (lo),
        .divisor  (opb),
        .next_rem (div_rem),
        .next_quo (div_quo)
    );

    // Multiply step: {hi,lo} holds running product above the unconsumed multiplier bits
    logic [XLEN:0]   add_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;

    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        mul_hi  = add_sum[XLEN:1];
        mul_lo  = {add_sum[0], lo[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_q ? -prod : prod;
        case (op)
            F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = neg_q ? -lo : lo;
            default:                      fix_res = neg_r ? -hi : hi;
        endcase
    end

    // Handshake: start is taken only in IDLE with kill low; busy covers CALC/FIX;
    // done pulses for one cycle with result valid, and result holds until the next done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op     <= F3_MUL;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (kill && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !kill) begin
                        op    <= funct3;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        hi    <= '0;
                        lo    <= is_div ? a_mag : b_mag;
                        opb   <= is_div ? b_mag : a_mag;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt   <= CW'(XLEN - 1);
                            busy  <= 1'b1;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi  <= op[2] ? div_rem : mul_hi;
                    lo  <= op[2] ? div_quo : mul_lo;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
